// File: rtl/bpsk_transmitter_pkg.sv
// Shared defaults and the carrier sine table for the BPSK transmitter.
// The table holds one carrier cycle of 14 samples at 8-bit amplitude.
package bpsk_transmitter_pkg;

    localparam int DATA_WIDTH_DEF      = 8;
    localparam int SINE_RESOLUTION_DEF = 7;
    localparam int WAVELENGTH_DEF      = 14;
    localparam int SHIFT_DEF           = 7;
    localparam int PACKET_SIZE_DEF     = 128;

    // round(128 + 127*sin(2*pi*p/14)); out-of-range phases return mid-scale
    function automatic logic [7:0] sine_lut(input logic [7:0] p);
        logic [7:0] v;
        case (p)
            8'd0:    v = 8'd128;
            8'd1:    v = 8'd183;
            8'd2:    v = 8'd227;
            8'd3:    v = 8'd252;
            8'd4:    v = 8'd252;
            8'd5:    v = 8'd227;
            8'd6:    v = 8'd183;
            8'd7:    v = 8'd128;
            8'd8:    v = 8'd73;
            8'd9:    v = 8'd29;
            8'd10:   v = 8'd4;
            8'd11:   v = 8'd4;
            8'd12:   v = 8'd29;
            8'd13:   v = 8'd73;
            default: v = 8'd128;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/bpsk_pwm.sv
// Free-running PWM: counter, duty compare, end-of-period tick, and the duty
// register that only reloads on that tick so a period's duty never changes.
module bpsk_pwm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] amp_next,
    output logic                  pwm_out,
    output logic                  sample_tick,
    output logic [DATA_WIDTH-1:0] amp
);

    logic [DATA_WIDTH-1:0] pwm_cnt_reg;
    logic [DATA_WIDTH-1:0] amp_reg;

    assign sample_tick = (pwm_cnt_reg == {DATA_WIDTH{1'b1}});
    assign pwm_out     = (pwm_cnt_reg < amp_reg);
    assign amp         = amp_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_reg <= '0;
            amp_reg     <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
            if (sample_tick) begin
                amp_reg <= amp_next;
            end
        end
    end

endmodule

// File: rtl/bpsk_transmitter.sv
// BPSK transmitter: carrier phase accumulator, sine lookup and packet serialiser
// feeding a PWM generator; a '1' bit shifts the carrier by half a cycle.
module bpsk_transmitter
    import bpsk_transmitter_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int SINE_RESOLUTION = SINE_RESOLUTION_DEF,
    parameter int WAVELENGTH      = WAVELENGTH_DEF,
    parameter int SHIFT           = SHIFT_DEF,
    parameter int PACKET_SIZE     = PACKET_SIZE_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PACKET_SIZE-1:0] packet,
    output logic                   pwm_out,
    output logic                   sample_tick,
    output logic                   current_bit,
    output logic [DATA_WIDTH-1:0]  tx_phase,
    output logic [DATA_WIDTH-1:0]  amp,
    output logic                   packet_done
);

    localparam int BIT_W = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;

    localparam logic [DATA_WIDTH:0]   WAVE_EXT   = (DATA_WIDTH+1)'(WAVELENGTH);
    localparam logic [DATA_WIDTH:0]   SHIFT_EXT  = (DATA_WIDTH+1)'(SHIFT);
    localparam logic [DATA_WIDTH-1:0] PHASE_LAST = DATA_WIDTH'(WAVELENGTH - 1);
    localparam logic [BIT_W-1:0]      IDX_LAST   = BIT_W'(PACKET_SIZE - 1);

    if (WAVELENGTH != 2 * SINE_RESOLUTION) begin : g_bad_wavelength
        $error("WAVELENGTH must equal 2*SINE_RESOLUTION");
    end
    if (SHIFT != WAVELENGTH / 2) begin : g_bad_shift
        $error("SHIFT must equal WAVELENGTH/2");
    end

    logic [DATA_WIDTH-1:0] phase_reg;
    logic [BIT_W-1:0]      bit_idx_reg;
    logic [BIT_W-1:0]      bit_pos;
    logic [DATA_WIDTH:0]   phase_sum;
    logic [DATA_WIDTH-1:0] amp_next;
    logic                  phase_wrap;

    // MSB first: bit_idx 0 selects packet[PACKET_SIZE-1]
    assign bit_pos     = IDX_LAST - bit_idx_reg;
    assign current_bit = packet[bit_pos];

    assign phase_sum = {1'b0, phase_reg} + (current_bit ? SHIFT_EXT : '0);
    assign tx_phase  = (phase_sum >= WAVE_EXT) ? DATA_WIDTH'(phase_sum - WAVE_EXT)
                                               : phase_sum[DATA_WIDTH-1:0];

    assign amp_next = DATA_WIDTH'(sine_lut(8'(tx_phase)));

    // A bit boundary always coincides with the carrier wrapping to phase 0
    assign phase_wrap  = sample_tick && (phase_reg == PHASE_LAST);
    assign packet_done = phase_wrap && (bit_idx_reg == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg   <= '0;
            bit_idx_reg <= '0;
        end else if (sample_tick) begin
            if (phase_wrap) begin
                phase_reg   <= '0;
                bit_idx_reg <= (bit_idx_reg == IDX_LAST) ? '0 : bit_idx_reg + 1'b1;
            end else begin
                phase_reg <= phase_reg + 1'b1;
            end
        end
    end

    bpsk_pwm #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pwm (
        .clk         (clk),
        .rst_n       (rst_n),
        .amp_next    (amp_next),
        .pwm_out     (pwm_out),
        .sample_tick (sample_tick),
        .amp         (amp)
    );

endmodule

// File: tb/tb_bpsk_transmitter.sv
// Randomized self-checking bench for bpsk_transmitter against a time-indexed
// model (sample = t/256, bit = sample/14) with a shortened packet length.
module tb_bpsk_transmitter;

    localparam int DW     = 8;
    localparam int WL     = 14;
    localparam int PS     = 4;
    localparam int PERIOD = 1 << DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PS-1:0] packet = '0;
    logic          pwm_out;
    logic          sample_tick;
    logic          current_bit;
    logic [DW-1:0] tx_phase;
    logic [DW-1:0] amp;
    logic          packet_done;

    int errors = 0;
    int checks = 0;

    // Model state
    int t = 0;
    int exp_amp = 0;
    int hi_cnt = 0;

    always #5 clk = ~clk;

    bpsk_transmitter #(
        .DATA_WIDTH      (DW),
        .SINE_RESOLUTION (7),
        .WAVELENGTH      (WL),
        .SHIFT           (7),
        .PACKET_SIZE     (PS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .packet      (packet),
        .pwm_out     (pwm_out),
        .sample_tick (sample_tick),
        .current_bit (current_bit),
        .tx_phase    (tx_phase),
        .amp         (amp),
        .packet_done (packet_done)
    );

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            errors++;
            $display("FAIL %s t=%0d got=%0d exp=%0d", tag, t, obs, exp_v);
        end
    endtask

    function automatic int lut_ref(input int p);
        real v;
        v = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * p / WL);
        return $rtoi(v + 0.5);
    endfunction

    function automatic int bit_of(input int sample, input logic [PS-1:0] pk);
        int idx;
        idx = (sample / WL) % PS;
        return int'(pk[PS-1-idx]);
    endfunction

    function automatic int txp_of(input int sample, input logic [PS-1:0] pk);
        return (sample % WL + 7 * bit_of(sample, pk)) % WL;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_pwm_out", int'(pwm_out), 0);
        check_eq("rst_sample_tick", int'(sample_tick), 0);
        check_eq("rst_amp", int'(amp), 0);
        check_eq("rst_packet_done", int'(packet_done), 0);
        check_eq("rst_tx_phase", int'(tx_phase), 7 * int'(packet[PS-1]));
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        t       = 0;
        exp_amp = 0;
        hi_cnt  = 0;
        $display("reset released, packet=%b", packet);
    endtask

    task automatic run_cycles(input int n, input bit change_on_done);
        int n_s, c, e_tick, e_done;
        for (int i = 0; i < n; i++) begin
            n_s    = t / PERIOD;
            c      = t % PERIOD;
            e_tick = (c == PERIOD - 1) ? 1 : 0;
            e_done = (e_tick == 1 && n_s % WL == WL - 1 && (n_s / WL) % PS == PS - 1) ? 1 : 0;
            check_eq("pwm_out", int'(pwm_out), (c < exp_amp) ? 1 : 0);
            check_eq("sample_tick", int'(sample_tick), e_tick);
            check_eq("current_bit", int'(current_bit), bit_of(n_s, packet));
            check_eq("tx_phase", int'(tx_phase), txp_of(n_s, packet));
            check_eq("amp", int'(amp), exp_amp);
            check_eq("packet_done", int'(packet_done), e_done);
            hi_cnt += int'(pwm_out);
            if (e_done == 1) begin
                $display("packet_done at t=%0d sample=%0d", t, n_s);
                if (change_on_done) begin
                    packet = PS'($urandom);
                    $display("packet changed to %b", packet);
                end
            end
            if (e_tick == 1) begin
                check_eq("period_high_count", hi_cnt, exp_amp);
                $display("sample %0d: high=%0d duty=%0d next_phase=%0d", n_s, hi_cnt,
                         exp_amp, txp_of(n_s, packet));
                hi_cnt  = 0;
                exp_amp = lut_ref(txp_of(n_s, packet));
            end
            t++;
            @(negedge clk);
        end
    endtask

    initial begin
        // All-zero packet: plain carrier, duty follows the LUT from phase 0
        packet = '0;
        do_reset();
        run_cycles(WL * PERIOD + 100, 1'b0);

        // MSB first with a 180 degree shift: phases 7,8,9...
        packet = PS'(1) << (PS - 1);
        do_reset();
        run_cycles(4 * PERIOD + 10, 1'b0);

        // Bits 1,0: flip at the first bit boundary
        packet = PS'(2) << (PS - 2);
        do_reset();
        run_cycles(2 * WL * PERIOD + 100, 1'b0);

        // Random payloads across two packet wraps, reloaded on packet_done
        packet = PS'($urandom);
        do_reset();
        run_cycles(2 * PS * WL * PERIOD + 200, 1'b1);

        // Asynchronous reset mid-bit, then the startup sequence again
        packet = PS'($urandom);
        do_reset();
        run_cycles(1000, 1'b0);
        do_reset();
        run_cycles(3 * PERIOD + 20, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bpsk_transmitter.md
# bpsk_transmitter

Synchronous BPSK transmitter that serialises a fixed-length packet onto a PWM-synthesised sine carrier for a single LED/pin output. It combines three functions: a PWM generator that emits a sample tick per period, a carrier phase accumulator that applies a 180° shift for '1' bits, and a packet serialiser. It sits directly behind the top-level pin. The packet content comes from a constant or register in the parent.

## Interface
- DATA_WIDTH, 8: amplitude width; the PWM period is 2^DATA_WIDTH clk.
- SINE_RESOLUTION, 7: sine samples per half carrier cycle.
- WAVELENGTH, 14: samples per carrier cycle; must equal 2*SINE_RESOLUTION.
- SHIFT, 7: phase offset, in samples, applied for a '1' bit; must equal WAVELENGTH/2.
- PACKET_SIZE, 128: bits per packet.
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- packet  in  PACKET_SIZE  payload; must be held stable while transmitting.
- pwm_out  out  1  modulated PWM output (drives the LED).
- sample_tick  out  1  one-cycle pulse on the last clk of each PWM period.
- current_bit  out  1  bit currently being transmitted.
- tx_phase  out  DATA_WIDTH  shifted carrier phase, 0..WAVELENGTH-1.
- amp  out  DATA_WIDTH  duty value of the current PWM period.
- packet_done  out  1  one-cycle pulse when the last bit of a packet ends.

## Operation
- PWM:
  - pwm_cnt is free-running, 0..2^DATA_WIDTH-1, and wraps.
  - pwm_out = (pwm_cnt < amp), unsigned compare.
  - sample_tick = (pwm_cnt == 2^DATA_WIDTH-1).
- Phase:
  - Carrier phase register `phase`, 0..WAVELENGTH-1.
  - On sample_tick, phase increments and wraps WAVELENGTH-1 -> 0.
  - tx_phase = (phase + (current_bit ? SHIFT : 0)) mod WAVELENGTH, combinational.
- Sine LUT (combinational):
  - lut(p) = round(2^(DATA_WIDTH-1) + (2^(DATA_WIDTH-1)-1)*sin(2πp/WAVELENGTH)).
  - Default values for p=0..13: 128,183,227,252,252,227,183,128,73,29,4,4,29,73.
- amp register: on sample_tick, amp <= lut(tx_phase) using the pre-update phase. The duty value therefore never changes mid-period.
- Serialiser:
  - bit_idx runs 0..PACKET_SIZE-1.
  - current_bit = packet[PACKET_SIZE-1-bit_idx]; the MSB is sent first.
  - bit_idx advances on the sample_tick where phase == WAVELENGTH-1, and wraps to 0 after PACKET_SIZE-1. Transmission is continuous and repeats.
  - packet_done is asserted on that wrapping tick.
- Simultaneous events: a bit advance and a phase wrap always coincide; the new bit's shift applies from the next sampled tx_phase.

## Timing
- Reset values: pwm_cnt=0, phase=0, bit_idx=0, amp=0, pwm_out=0, sample_tick=0, packet_done=0.
- Asynchronous reset mid-operation returns the block to this state immediately. No partial-packet resume.
- First PWM period after reset: pwm_out stays low (amp=0).
- amp lags its phase by one PWM period (2^DATA_WIDTH clk).
- Durations at the defaults:
  - 1 sample = 256 clk.
  - 1 bit = WAVELENGTH*256 = 3584 clk.
  - 1 packet = 458752 clk.
- First sample_tick at clk cycle 255 after reset release.
- First bit boundary at cycle 14*256-1.
- A change of packet takes effect combinationally on current_bit. It is legal only while packet_done is asserted.

## Structure
- Shared package: the DATA_WIDTH/WAVELENGTH/SHIFT/PACKET_SIZE defaults and the sine LUT function or constant array.
- One sub-module, bpsk_pwm: the counter, compare, sample_tick and amp register.
- The phase accumulator, LUT and serialiser stay in the top.

## Test plan
- Reset, then packet=0:
  - pwm_out is low for cycles 0..255.
  - The next period is high for exactly 128 clk.
  - Subsequent periods are high for 183, 227, 252 clk.
- Packet MSB=1 (packet=1<<127): the first periods use tx_phase 7,8,9 -> duty 128,73,29.
- Bit boundary: packet=2'b10<<126 (bits 1,0):
  - After 14 sample_ticks, current_bit goes 1->0.
  - tx_phase jumps by 7 mod 14 (a 180° flip).
  - packet_done stays 0.
- Packet wrap: after 128*14 sample_ticks, packet_done pulses for exactly 1 clk, bit_idx=0 and current_bit=packet[127].
- Assert rst_n low mid-bit (cycle ~1000): all outputs return to reset values asynchronously, and the first-period-low sequence repeats after release.
- Duty check over one full carrier with current_bit=0: measured high counts equal the 14 LUT values in order, with no glitch at period edges.
